// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH product
// in WIDTH iterations over one shared ripple-carry adder, with a start/busy/done handshake.

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);
  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  logic [1:0]       r_state;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_product;

  logic             w_sub;
  logic [PW-1:0]    w_addend;
  logic [PW-1:0]    w_addend_x;
  logic [PW-1:0]    w_carry;
  logic [PW-1:0]    w_sum;

  // Shared adder: the add/sub cell chain with subtract held low.
  assign w_sub      = 1'b0;
  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_addend_x = w_addend ^ {PW{w_sub}};
  assign w_carry[0] = w_sub;

  genvar gi;
  generate
    for (gi = 0; gi < PW - 1; gi++) begin : g_fa
      full_adder u_fa (
        .i_a   (r_acc[gi]),
        .i_b   (w_addend_x[gi]),
        .i_cin (w_carry[gi]),
        .o_s   (w_sum[gi]),
        .o_cout(w_carry[gi+1])
      );
    end
  endgenerate

  // Top bit: the partial sum never exceeds 2*WIDTH bits, so its carry-out is dropped.
  assign w_sum[PW-1] = r_acc[PW-1] ^ w_addend_x[PW-1] ^ w_carry[PW-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CNT_LAST) begin
            r_product <= w_sum;
            r_state   <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign product = r_product;
endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: an 8-bit and a 4-bit instance checked against
// plain integer multiplication and the start-to-done cycle counts.

module tb_seq_multiplier;
  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start4;
  logic [7:0]  a8, b8;
  logic [3:0]  a4, b4;
  logic        busy8, done8, busy4, done4;
  logic [15:0] prod8;
  logic [7:0]  prod4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  seq_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(prod4)
  );

  // Issue one 8-bit multiply; index n counts observations after edge E0+n.
  task automatic run8(input logic [7:0] x, input logic [7:0] y,
                      output logic [15:0] p, output int bcnt, output int didx,
                      output int ndone, output bit ovl);
    bcnt = 0; didx = -1; ndone = 0; ovl = 1'b0;
    @(negedge clk);
    a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (busy8) bcnt++;
      if (done8) begin
        ndone++;
        if (didx < 0) didx = n;
      end
      if (busy8 && done8) ovl = 1'b1;
    end
    p = prod8;
  endtask

  task automatic test_reset();
    rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy8); end
    n_checks++;
    if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done8); end
    n_checks++;
    if (prod8 !== 16'h0000) begin n_fail++; $display("FAIL reset_product got %h want 0000", prod8); end
    n_checks++;
    if (prod4 !== 8'h00 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      n_fail++; $display("FAIL reset_w4 got p=%h b=%b d=%b want 00/0/0", prod4, busy4, done4);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] p; int bcnt, didx, nd; bit ovl;
    run8(8'd13, 8'd11, p, bcnt, didx, nd, ovl);
    n_checks++;
    if (p !== 16'h008F) begin n_fail++; $display("FAIL basic_product got %h want 008f", p); end
    n_checks++;
    if (bcnt != 8) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 8", bcnt); end
    n_checks++;
    if (didx != 8) begin n_fail++; $display("FAIL basic_done_edge got %0d want 8", didx); end
    n_checks++;
    if (nd != 1 || ovl) begin n_fail++; $display("FAIL basic_done_pulses got %0d ovl=%b want 1 ovl=0", nd, ovl); end
    repeat (20) @(negedge clk);
    n_checks++;
    if (prod8 !== 16'h008F) begin n_fail++; $display("FAIL basic_hold got %h want 008f", prod8); end
  endtask

  task automatic test_corners();
    logic [7:0]  ta[4] = '{8'h00, 8'hFF, 8'h80, 8'h01};
    logic [7:0]  tb[4] = '{8'hFF, 8'hFF, 8'h02, 8'h01};
    logic [15:0] tp[4] = '{16'h0000, 16'hFE01, 16'h0100, 16'h0001};
    logic [15:0] p; int bcnt, didx, nd; bit ovl;
    for (int i = 0; i < 4; i++) begin
      run8(ta[i], tb[i], p, bcnt, didx, nd, ovl);
      n_checks++;
      if (p !== tp[i] || didx != 8) begin
        n_fail++;
        $display("FAIL corner_%0d got p=%h done_edge=%0d want p=%h done_edge=8", i, p, didx, tp[i]);
      end
    end
  endtask

  task automatic test_start_during_run();
    int nd = 0, didx = -1;
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (n == 2) begin a8 = 8'h05; b8 = 8'h05; start8 = 1'b1; end
      if (done8) begin nd++; if (didx < 0) didx = n; end
    end
    n_checks++;
    if (nd != 1 || didx != 8) begin
      n_fail++; $display("FAIL ignore_start_pulses got %0d at edge %0d want 1 at 8", nd, didx);
    end
    n_checks++;
    if (prod8 !== 16'h03A8) begin n_fail++; $display("FAIL ignore_start_product got %h want 03a8", prod8); end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] p; int bcnt, didx, nd2; bit ovl;
    int nd = 0;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0000) begin
      n_fail++; $display("FAIL midrun_reset got b=%b d=%b p=%h want 0/0/0000", busy8, done8, prod8);
    end
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done8) nd++;
    end
    n_checks++;
    if (nd != 0) begin n_fail++; $display("FAIL midrun_no_done got %0d pulses want 0", nd); end
    run8(8'h03, 8'h07, p, bcnt, didx, nd2, ovl);
    n_checks++;
    if (p !== 16'h0015 || didx != 8) begin
      n_fail++; $display("FAIL midrun_fresh got p=%h edge=%0d want 0015 edge=8", p, didx);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  ra[60];
    logic [7:0]  rb[60];
    logic [15:0] expv;
    int last = -1, nd = 0;
    bit ovl = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k > 0) begin
        int e;
        e = k - 1;
        if (busy8 && done8) ovl = 1'b1;
        if (done8) begin
          nd++;
          n_checks++;
          if (e < 8) begin
            n_fail++; $display("FAIL b2b_early_done got edge %0d want >=8", e);
          end else begin
            expv = 16'(ra[e-8]) * 16'(rb[e-8]);
            if (prod8 !== expv) begin
              n_fail++; $display("FAIL b2b_product got %h want %h at edge %0d", prod8, expv, e);
            end
          end
          n_checks++;
          if ((last < 0 && e != 8) || (last >= 0 && e - last != 10)) begin
            n_fail++; $display("FAIL b2b_interval got edge %0d prev %0d want spacing 10", e, last);
          end
          last = e;
        end
      end
      ra[k] = 8'($urandom); rb[k] = 8'($urandom);
      a8 = ra[k]; b8 = rb[k]; start8 = 1'b1;
    end
    @(negedge clk);
    start8 = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++;
    if (nd != 6 || ovl) begin
      n_fail++; $display("FAIL b2b_count got %0d dones ovl=%b want 6 ovl=0", nd, ovl);
    end
  endtask

  task automatic test_random();
    logic [15:0] p; int bcnt, didx, nd; bit ovl;
    logic [7:0] x, y;
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom); y = 8'($urandom);
      run8(x, y, p, bcnt, didx, nd, ovl);
      n_checks++;
      if (p !== 16'(x) * 16'(y) || didx != 8 || bcnt != 8) begin
        n_fail++;
        $display("FAIL random %h*%h got p=%h edge=%0d busy=%0d want p=%h edge=8 busy=8",
                 x, y, p, didx, bcnt, 16'(x) * 16'(y));
      end
    end
  endtask

  task automatic test_width4();
    int didx;
    logic [7:0] expv;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        @(negedge clk);
        a4 = 4'(x); b4 = 4'(y); start4 = 1'b1;
        @(posedge clk);
        didx = -1;
        for (int n = 0; n < 8; n++) begin
          @(negedge clk);
          start4 = 1'b0;
          if (done4 && didx < 0) didx = n;
        end
        expv = 8'(x * y);
        n_checks++;
        if (prod4 !== expv || didx != 4) begin
          n_fail++; $display("FAIL w4 %0d*%0d got p=%h edge=%0d want p=%h edge=4", x, y, prod4, didx, expv);
        end
      end
    end
    n_checks++;
    if (prod4 !== 8'hE1) begin n_fail++; $display("FAIL w4_last got %h want e1", prod4); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_start_during_run();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    test_width4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
